// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the core's execute-stage memory instruction onto a simple
// request/grant + rvalid memory bus. One transaction is outstanding at most.
//
// Handshake semantics:
//   Core side: the core raises data_req_i with all *_i fields valid and keeps
//   them stable while stall_o is high. Completion is a single-cycle done_o pulse;
//   rd_data_o / misaligned_o / bus_err_o are valid only with done_o and are
//   0 at all other times.
//   Memory side: mem_req_o stays high with constant address/wr/wstrb/wdata
//   until a cycle where mem_gnt_i=1 (accepted). mem_rvalid_i=1 returns load
//   data or acknowledges a store, either in the grant cycle or later.
//   gnt/rvalid seen while no request is outstanding are ignored.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   data_req_i, data_wr_i       request, 1=store / 0=load
//   data_byte_i                 00 byte, 01 half, 10 word, 11 invalid
//   zero_extnd_i                load zero-extend (1) / sign-extend (0)
//   addr_i, wr_data_i           byte address, store data
//   stall_o, done_o             core hold, completion pulse
//   rd_data_o                   formatted load data
//   misaligned_o, bus_err_o     exception flags
//   mem_req_o .. mem_wdata_o    memory request channel
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                 memory response channel
//   dbg_state_o                 FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 RESP
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_byte_i,
    input  logic        zero_extnd_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rd_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Last REQ/WAIT cycle index before the bus is declared dead.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic        zext_q, zext_d;
    logic        misal_q, misal_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        misal_in;
    logic [31:0] lane_data;
    logic [31:0] load_fmt;
    logic [3:0]  wstrb;
    logic [31:0] wdata_rep;

    // Alignment of the incoming request.
    always_comb begin
        misal_in = 1'b0;
        case (data_byte_i)
            SZ_BYTE: misal_in = 1'b0;
            SZ_HALF: misal_in = addr_i[0];
            SZ_WORD: misal_in = |addr_i[1:0];
            default: misal_in = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        wr_d    = wr_q;
        zext_d  = zext_q;
        misal_d = misal_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (data_req_i) begin
                    addr_d  = addr_i;
                    wdata_d = wr_data_i;
                    size_d  = data_byte_i;
                    wr_d    = data_wr_i;
                    zext_d  = zero_extnd_i;
                    misal_d = misal_in;
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                    cnt_d   = 8'h0;
                    state_d = misal_in ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                // A completing response wins over the timeout in the same cycle.
                if (mem_gnt_i && mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                    if (mem_gnt_i) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            default: begin
                // RESP: the retiring instruction still holds data_req_i; ignore it.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'b00;
            wr_q    <= 1'b0;
            zext_q  <= 1'b0;
            misal_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            zext_q  <= zext_d;
            misal_q <= misal_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store lane steering from the latched request.
    always_comb begin
        wstrb     = 4'b0000;
        wdata_rep = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                wstrb     = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                wstrb     = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Load formatting: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        lane_data = rdata_q >> {addr_q[1:0], 3'b000};
        load_fmt  = lane_data;
        case (size_q)
            SZ_BYTE: load_fmt = zext_q ? {24'h0, lane_data[7:0]}
                                       : {{24{lane_data[7]}}, lane_data[7:0]};
            SZ_HALF: load_fmt = zext_q ? {16'h0, lane_data[15:0]}
                                       : {{16{lane_data[15]}}, lane_data[15:0]};
            default: load_fmt = lane_data;
        endcase
    end

    assign mem_req_o    = (state_q == S_REQ);
    assign mem_addr_o   = mem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wr_o     = mem_req_o & wr_q;
    assign mem_wstrb_o  = (mem_req_o && wr_q) ? wstrb : 4'b0000;
    assign mem_wdata_o  = (mem_req_o && wr_q) ? wdata_rep : 32'h0;

    assign stall_o      = ((state_q == S_IDLE) & data_req_i) |
                          (state_q == S_REQ) | (state_q == S_WAIT);
    assign done_o       = (state_q == S_RESP);
    assign misaligned_o = done_o & misal_q;
    assign bus_err_o    = done_o & err_q;
    assign rd_data_o    = (done_o && !wr_q && !misal_q && !err_q) ? load_fmt : 32'h0;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed and randomized transactions against load_store_unit with TIMEOUT=4.
// A small memory responder grants after g cycles of request and returns rvalid
// r cycles after the grant; the expected cycle-by-cycle behaviour is derived
// from those delays and the access rules, not from the DUT's state machine.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        resetn;
    logic        data_req_i;
    logic        data_wr_i;
    logic [1:0]  data_byte_i;
    logic        zero_extnd_i;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rd_data_o;
    logic        misaligned_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_wr_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_req_i   (data_req_i),
        .data_wr_i    (data_wr_i),
        .data_byte_i  (data_byte_i),
        .zero_extnd_i (zero_extnd_i),
        .addr_i       (addr_i),
        .wr_data_i    (wr_data_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rd_data_o    (rd_data_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wr_o     (mem_wr_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_misal(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic zx,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a[1:0]));
        if (sz == 2'd0) begin
            if (zx || !v[7]) v = v & 32'h0000_00FF;
            else             v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            if (zx || !v[15]) v = v & 32'h0000_FFFF;
            else              v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Byte lanes touched by a store, and what each lane carries.
    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             output logic [3:0] strb, output logic [31:0] data);
        int ofs;
        ofs  = int'(a[1:0]);
        strb = 4'b0000;
        data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (sz == 2'd2) begin
                strb[i] = 1'b1;
                data[8*i +: 8] = wd[8*i +: 8];
            end else if (sz == 2'd1) begin
                strb[i] = (i == ofs) || (i == ofs + 1);
                data[8*i +: 8] = wd[8*(i%2) +: 8];
            end else begin
                strb[i] = (i == ofs);
                data[8*i +: 8] = wd[7:0];
            end
        end
    endtask

    // ---------------- driver ----------------
    // One transaction. g: cycles of mem_req_o before gnt; r: cycles from gnt to rvalid.
    // Cycle n=0 is the IDLE cycle carrying the request; n=d is the done cycle.
    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic zx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int g, input int r);
        logic        mis;
        logic        exp_err;
        int          d;
        int          c;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        logic        exp_req;
        mis = ref_misal(sz, a);
        c   = g + 1 + r;
        if (mis) begin
            d = 1; exp_err = 1'b0;
        end else if (c <= TO) begin
            d = c + 1; exp_err = 1'b0;
        end else begin
            d = TO + 1; exp_err = 1'b1;
        end
        ref_store(sz, a, wd, exp_strb, exp_wdata);
        exp_rd = (wr || mis || exp_err) ? 32'h0 : ref_load(sz, zx, a, rd);

        for (int n = 0; n <= d + 1; n++) begin
            @(negedge clk);
            if (n == 0) begin
                data_req_i   = 1'b1;
                data_wr_i    = wr;
                data_byte_i  = sz;
                zero_extnd_i = zx;
                addr_i       = a;
                wr_data_i    = wd;
                mem_rdata_i  = rd;
            end
            if (n == d + 1) data_req_i = 1'b0;
            mem_gnt_i    = !mis && (n == g + 1);
            mem_rvalid_i = !mis && (n == c);
            #1;
            exp_req = !mis && (n >= 1) && (n < d) && (n <= g + 1);
            chk($sformatf("%s n%0d stall", tag, n), 32'(stall_o), 32'(n < d));
            chk($sformatf("%s n%0d done", tag, n), 32'(done_o), 32'(n == d));
            chk($sformatf("%s n%0d mem_req", tag, n), 32'(mem_req_o), 32'(exp_req));
            if (exp_req) begin
                chk($sformatf("%s n%0d mem_addr", tag, n), mem_addr_o, a & 32'hFFFF_FFFC);
                chk($sformatf("%s n%0d mem_wr", tag, n), 32'(mem_wr_o), 32'(wr));
                chk($sformatf("%s n%0d wstrb", tag, n), 32'(mem_wstrb_o),
                    wr ? 32'(exp_strb) : 32'h0);
                if (wr) chk($sformatf("%s n%0d wdata", tag, n), mem_wdata_o, exp_wdata);
            end
            if (n == d) begin
                chk($sformatf("%s rd_data", tag), rd_data_o, exp_rd);
                chk($sformatf("%s misaligned", tag), 32'(misaligned_o), 32'(mis));
                chk($sformatf("%s bus_err", tag), 32'(bus_err_o), 32'(exp_err));
            end else begin
                chk($sformatf("%s n%0d flags_idle", tag, n),
                    {rd_data_o[31:2], rd_data_o[1:0] | {misaligned_o, bus_err_o}}, 32'h0);
            end
            if (n == d + 1) chk($sformatf("%s idle_state", tag), 32'(dbg_state_o), 32'h0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn       = 1'b0;
        data_req_i   = 1'b0;
        data_wr_i    = 1'b0;
        data_byte_i  = 2'b00;
        zero_extnd_i = 1'b0;
        addr_i       = 32'h0;
        wr_data_i    = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset state", 32'(dbg_state_o), 32'h0);
        chk("reset outs", {stall_o, done_o, misaligned_o, bus_err_o, mem_req_o, mem_wr_o,
                           mem_wstrb_o}, 32'h0);
        chk("reset buses", rd_data_o | mem_addr_o | mem_wdata_o, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed vectors
        txn("LB_1003",  1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,         32'h80FF_FF00, 0, 1);
        txn("SH_2002",  1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 1);
        txn("LW_3001",  1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0,         32'h0,         0, 0);
        txn("LHU_4002", 1'b0, 2'd1, 1'b1, 32'h0000_4002, 32'h0,         32'h8765_0000, 3, 0);
        txn("TIMEOUT",  1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0,         32'h1111_2222, 10, 0);
        txn("SB_0001",  1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'hCAFE_F00D, 32'h0,         1, 2);
        txn("SZ11_ST",  1'b1, 2'd3, 1'b0, 32'h0000_6000, 32'h5555_5555, 32'h0,         0, 0);
        txn("LH_neg",   1'b0, 2'd1, 1'b0, 32'h0000_7000, 32'h0,         32'h0000_9ABC, 0, 0);
        txn("WAIT_TO",  1'b1, 2'd2, 1'b0, 32'h0000_8004, 32'hA5A5_5A5A, 32'h0,         1, 5);

        // Reset during WAIT; a late rvalid must be ignored.
        @(negedge clk);
        data_req_i = 1'b1; data_wr_i = 1'b0; data_byte_i = 2'd2; addr_i = 32'h0000_9000;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0; data_req_i = 1'b0;
        #1;
        chk("rst_wait in_wait", 32'(dbg_state_o), 32'd2);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_wait state", 32'(dbg_state_o), 32'h0);
        chk("rst_wait outs", {stall_o, done_o, mem_req_o, misaligned_o, bus_err_o}, 32'h0);
        chk("rst_wait buses", rd_data_o | mem_addr_o, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            #1;
            chk($sformatf("rst_after done k%0d", k), 32'(done_o), 32'h0);
            chk($sformatf("rst_after state k%0d", k), 32'(dbg_state_o), 32'h0);
            chk($sformatf("rst_after outs k%0d", k), {stall_o, mem_req_o, rd_data_o[30:0]}, 32'h0);
        end

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            logic        wr;
            logic [1:0]  sz;
            logic        zx;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            zx = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            txn($sformatf("rnd%0d", t), wr, sz, zx, a, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
